// File: rtl/bbus_pkg.sv
// rtl/bbus_pkg.sv - shared types and constants for the BBUS debug initiator
package bbus_pkg;

    localparam int BbusDataWidth = 32;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } bbus_state_e;

    typedef struct packed {
        logic                     write;
        logic [BbusDataWidth-1:0] addr;
        logic [BbusDataWidth-1:0] wdata;
    } bbus_cmd_t;

    typedef struct packed {
        logic [BbusDataWidth-1:0] data;
        logic                     err;
    } bbus_rsp_t;

endpackage

// File: rtl/bbus_if.sv
// rtl/bbus_if.sv - BBUS single-transaction bus between an initiator and a debug target
interface BBUS_IF;
    import bbus_pkg::*;

    logic                     read_en;
    logic                     write_en;
    logic [BbusDataWidth-1:0] addr;
    logic [BbusDataWidth-1:0] wdata;
    logic [BbusDataWidth-1:0] rdata;
    logic                     read_ack;
    logic                     write_ack;

    modport master (
        output read_en, write_en, addr, wdata,
        input  rdata, read_ack, write_ack
    );

    modport slave (
        input  read_en, write_en, addr, wdata,
        output rdata, read_ack, write_ack
    );

endinterface

// File: rtl/bbus_timeout_counter.sv
// rtl/bbus_timeout_counter.sv - ack-wait counter, expired once timeout_cycles-1 idle bus cycles elapse
module bbus_timeout_counter #(
    parameter int timeout_cycles = 64,
    parameter int cnt_width      = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [cnt_width-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + cnt_width'(1);
        end
    end

    assign expired = (count == cnt_width'(timeout_cycles - 1));

endmodule

// File: rtl/bbus_master.sv
// rtl/bbus_master.sv - debug-side BBUS initiator, one transaction at a time; BBUS_TIMEOUT_EN adds ack timeout
module bbus_master
    import bbus_pkg::*;
#(
    parameter int timeout_cycles = 64,
    parameter int cnt_width      = 16
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iCmdValid,
    output logic                     oCmdReady,
    input  logic                     iCmdWrite,
    input  logic [BbusDataWidth-1:0] iCmdAddr,
    input  logic [BbusDataWidth-1:0] iCmdWdata,
    output logic                     oRspValid,
    input  logic                     iRspReady,
    output logic [BbusDataWidth-1:0] oRspData,
    output logic                     oRspErr,
    BBUS_IF.master                   bus
);

    bbus_state_e state;
    bbus_cmd_t   cmd;
    bbus_rsp_t   rsp;
    logic        busy;
    logic        ack;
    logic        timeout_hit;

    // Acks only count while a transaction is on the bus; stale registered acks are dropped.
    assign busy = (state == READ) || (state == WRITE);
    assign ack  = busy && (cmd.write ? bus.write_ack : bus.read_ack);

`ifdef BBUS_TIMEOUT_EN
    bbus_timeout_counter #(
        .timeout_cycles(timeout_cycles),
        .cnt_width     (cnt_width)
    ) u_timeout (
        .clk    (iClk),
        .rst    (iRst),
        .clear  (state == IDLE),
        .enable (busy && !ack),
        .expired(timeout_hit)
    );
`else
    logic unused_cfg;
    assign unused_cfg  = ^{timeout_cycles, cnt_width};
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state        <= IDLE;
            cmd          <= '0;
            rsp          <= '0;
            oCmdReady    <= 1'b0;
            oRspValid    <= 1'b0;
            bus.read_en  <= 1'b0;
            bus.write_en <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    oCmdReady <= 1'b1;
                    if (iCmdValid && oCmdReady) begin
                        cmd          <= '{write: iCmdWrite, addr: iCmdAddr, wdata: iCmdWdata};
                        oCmdReady    <= 1'b0;
                        bus.read_en  <= !iCmdWrite;
                        bus.write_en <= iCmdWrite;
                        state        <= iCmdWrite ? WRITE : READ;
                    end
                end
                READ, WRITE: begin
                    // An ack coinciding with expiry wins over the timeout.
                    if (ack) begin
                        rsp.data     <= cmd.write ? '0 : bus.rdata;
                        rsp.err      <= 1'b0;
                        oRspValid    <= 1'b1;
                        bus.read_en  <= 1'b0;
                        bus.write_en <= 1'b0;
                        state        <= RESP;
                    end else if (timeout_hit) begin
                        rsp.data     <= '0;
                        rsp.err      <= 1'b1;
                        oRspValid    <= 1'b1;
                        bus.read_en  <= 1'b0;
                        bus.write_en <= 1'b0;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (iRspReady) begin
                        oRspValid <= 1'b0;
                        oCmdReady <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.addr  = cmd.addr;
    assign bus.wdata = cmd.wdata;
    assign oRspData  = rsp.data;
    assign oRspErr   = rsp.err;

endmodule

// File: tb/tb_bbus_master.sv
// tb/tb_bbus_master.sv - self-checking bench for bbus_master with a delay-configurable memory slave
module tb_bbus_master;
    import bbus_pkg::*;

`ifdef BBUS_TIMEOUT_EN
    localparam int TmoCycles = 8;
`else
    localparam int TmoCycles = 64;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    int total = 0;
    int bad   = 0;
    int mon_bad = 0;

    BBUS_IF bus();

    bbus_master #(.timeout_cycles(TmoCycles), .cnt_width(16)) dut (
        .iClk     (clk),
        .iRst     (rst),
        .iCmdValid(cmd_valid),
        .oCmdReady(cmd_ready),
        .iCmdWrite(cmd_write),
        .iCmdAddr (cmd_addr),
        .iCmdWdata(cmd_wdata),
        .oRspValid(rsp_valid),
        .iRspReady(rsp_ready),
        .oRspData (rsp_data),
        .oRspErr  (rsp_err),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Memory slave: read ack after rd_delay enable cycles (0 = same cycle), registered write ack.
    logic [31:0] mem [16];
    int          en_age;
    int          rd_delay;
    logic        mute;

    assign bus.rdata    = mem[bus.addr[3:0]];
    assign bus.read_ack = bus.read_en && !mute && (en_age == rd_delay);

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= (i == 5) ? 32'hDEADBEEF : 32'h0;
            en_age        <= 0;
            bus.write_ack <= 1'b0;
        end else begin
            en_age        <= (bus.read_en || bus.write_en) ? en_age + 1 : 0;
            bus.write_ack <= bus.write_en && !mute;
            if (bus.write_en) mem[bus.addr[3:0]] <= bus.wdata;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.read_en && bus.write_en) mon_bad++;
            if ((bus.read_en || bus.write_en) && rsp_valid) mon_bad++;
        end
    end

    bbus_rsp_t exp_q[$];

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] exp_data;
        int          exp_lat;
        int          exp_en;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issues one command, returns in the first cycle oRspValid is seen high (not yet consumed).
    task automatic run_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp_d, input logic exp_err,
                           input int exp_lat, input int exp_en, input string tag);
        int        waited = 0;
        int        lat;
        int        en_cycles = 0;
        bbus_rsp_t exp;
        while (!cmd_ready && waited < 50) begin
            tick();
            waited++;
        end
        check({tag, " cmd_ready"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
        exp_q.push_back('{data: exp_d, err: exp_err});
        lat = 1;
        while (!rsp_valid && lat < 200) begin
            if (bus.read_en || bus.write_en) en_cycles++;
            tick();
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " enable_cycles"}, en_cycles, exp_en);
        check({tag, " resp_enables_low"}, {bus.read_en, bus.write_en}, 0);
        if (exp_q.size() == 0) begin
            check({tag, " scoreboard_empty"}, 1, 0);
        end else begin
            exp = exp_q.pop_front();
            check({tag, " data"}, rsp_data, exp.data);
            check({tag, " err"}, rsp_err, exp.err);
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'd3,  32'h12345678, 0, 32'h0,        3, 2};
        vecs[1] = '{1'b0, 32'd3,  32'h0,        0, 32'h12345678, 2, 1};
        vecs[2] = '{1'b0, 32'd5,  32'h0,        0, 32'hDEADBEEF, 2, 1};
        vecs[3] = '{1'b1, 32'd10, 32'hAAAA5555, 0, 32'h0,        3, 2};
        vecs[4] = '{1'b0, 32'd10, 32'hFFFFFFFF, 3, 32'hAAAA5555, 5, 4};
        vecs[5] = '{1'b0, 32'd0,  32'h0,        1, 32'h0,        3, 2};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;
        mute      = 1'b0;
        rd_delay  = 0;
        repeat (3) tick();

        check("rst cmd_ready", cmd_ready, 0);
        check("rst rsp_valid", rsp_valid, 0);
        check("rst rsp_data", rsp_data, 0);
        check("rst rsp_err", rsp_err, 0);
        check("rst enables", {bus.read_en, bus.write_en}, 0);
        check("rst addr", bus.addr, 0);
        check("rst wdata", bus.wdata, 0);
        rst = 1'b0;
        tick();
        check("post_rst cmd_ready", cmd_ready, 1);

        // Back-to-back commands with the response channel always ready.
        for (int i = 0; i < 6; i++) begin
            rd_delay = vecs[i].delay;
            run_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_data, 1'b0,
                    vecs[i].exp_lat, vecs[i].exp_en, $sformatf("vec%0d", i));
            tick();
            check($sformatf("vec%0d idle_rsp_valid", i), rsp_valid, 0);
        end
        rd_delay = 0;

        // Response back-pressure with a competing command held pending.
        rsp_ready = 1'b0;
        run_cmd(1'b0, 32'd5, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1, "hold");
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'd7;
        cmd_wdata = 32'h77;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("hold%0d state", i),
                  {rsp_valid, rsp_data, cmd_ready, bus.write_en},
                  {1'b1, 32'hDEADBEEF, 1'b0, 1'b0});
        end
        rsp_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("hold released", {rsp_valid, cmd_ready, bus.write_en}, {1'b0, 1'b1, 1'b0});

`ifdef BBUS_TIMEOUT_EN
        mute = 1'b1;
        run_cmd(1'b0, 32'd2, 32'h0, 32'h0, 1'b1, TmoCycles + 1, TmoCycles, "timeout");
        tick();
        mute     = 1'b0;
        rd_delay = TmoCycles - 1;
        run_cmd(1'b0, 32'd5, 32'h0, 32'hDEADBEEF, 1'b0, TmoCycles + 1, TmoCycles, "ack_at_expiry");
        tick();
        rd_delay = 0;
`endif

        // Reset in the second cycle of a write.
        check("rst_mid cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'd9;
        cmd_wdata = 32'h99;
        tick();
        cmd_valid = 1'b0;
        check("rst_mid write_en_1", bus.write_en, 1);
        tick();
        check("rst_mid write_en_2", bus.write_en, 1);
        rst = 1'b1;
        tick();
        check("rst_mid after_edge", {bus.write_en, bus.read_en, rsp_valid, cmd_ready}, 0);
        rst = 1'b0;
        tick();
        check("rst_mid cmd_ready_back", cmd_ready, 1);
        tick();
        check("rst_mid no_response", rsp_valid, 0);

        check("monitor enable_rules", mon_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bbus_master.md
# bbus_master

Debug-side initiator for the BBUS slave interface: accepts single read/write commands over a valid/ready channel, drives one BBUS transaction at a time into any `BBUS_IF.slave` target (e.g. the register file debug port), and returns read data or a completion/error status over a valid/ready response channel. It sits between the debug front-end (command decoder) and the BBUS-attached debug targets.

## Interface
Parameters:
- `timeout_cycles`, 64: bus cycles to wait for an ack before aborting; legal range 2..65535.
- `cnt_width`, 16: width of the timeout counter.

Ports:
- `iClk` in 1: single clock; all logic on the rising edge.
- `iRst` in 1: synchronous, active-high reset.
- `iCmdValid` in 1: command present.
- `oCmdReady` out 1: command accepted when high with `iCmdValid`.
- `iCmdWrite` in 1: 1 = write, 0 = read.
- `iCmdAddr` in 32: target address.
- `iCmdWdata` in 32: write data (ignored for reads).
- `oRspValid` out 1: response present.
- `iRspReady` in 1: response consumed when high with `oRspValid`.
- `oRspData` out 32: read data; 0 for writes and errors.
- `oRspErr` out 1: 1 = timeout abort.
- `bus` `BBUS_IF.master`: drives `read_en`, `write_en`, `addr[31:0]`, `wdata[31:0]`; samples `rdata[31:0]`, `read_ack`, `write_ack`.

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE: `oCmdReady`=1. On `iCmdValid`: latch addr/wdata/write, clear timeout counter, go WRITE or READ.
- READ: `read_en`=1, `addr` = latched addr. On `read_ack`: capture `rdata` into `oRspData`, `oRspErr`=0, go RESP.
- WRITE: `write_en`=1, `addr`/`wdata` held. On `write_ack`: `oRspData`=0, `oRspErr`=0, go RESP.
- RESP: `oRspValid`=1, bus enables 0. On `iRspReady`: go IDLE.
- Acks are sampled only in READ/WRITE; acks seen in IDLE/RESP (stale registered acks) are ignored.
- Enables and addr/wdata stay stable for the whole transaction; a slave re-writing the same value on a multi-cycle write is acceptable.
- At most one outstanding transaction; commands are not accepted in READ, WRITE or RESP.
- `read_en` and `write_en` are never high together.

## Timing
- All outputs are registered from FSM state/latches; no combinational path from `iCmd*` or ack inputs to any output.
- Reset values: `oCmdReady`=0 during reset, 1 in the first cycle after; `oRspValid`=0, `oRspData`=0, `oRspErr`=0, `read_en`=0, `write_en`=0, `addr`=0, `wdata`=0; state IDLE.
- Command accepted at edge N: enable is high in cycle N+1.
- Same-cycle (combinational) read ack: `oRspValid` is high in cycle N+2.
- Registered write ack (one cycle after `write_en`): `oRspValid` is high in cycle N+3.
- The enable drops in the cycle after the ack is sampled. At least one cycle of enables low always separates back-to-back transactions (RESP state).
- Reset mid-transaction: at the next edge the enables drop, any pending response is discarded, and the FSM is in IDLE.

## Configuration
- `BBUS_TIMEOUT_EN` defined: the counter increments each READ/WRITE cycle without an ack. When it reaches `timeout_cycles`-1 with no ack, the enables drop, the FSM goes to RESP with `oRspErr`=1 and `oRspData`=0. An ack in the same cycle as expiry wins, giving a normal response.
- Not defined: no counter is built, the FSM waits indefinitely for an ack, and `oRspErr` is tied to 0.

## Structure
- Shared package `bbus_pkg`:
  - `bbus_cmd_t` struct (write, addr, wdata).
  - `bbus_rsp_t` struct (data, err).
  - `bbus_state_e` enum for the FSM states.
  - Constant `BbusDataWidth`=32.
- One natural sub-module, `bbus_timeout_counter`: clear/enable inputs, an expired output, parameterised by `timeout_cycles`. It is instantiated only under `BBUS_TIMEOUT_EN`.

## Test plan
- Read addr 5 from a same-cycle-ack slave returning 0xDEADBEEF -> `oRspValid` is high 2 cycles after accept, `oRspData`=0xDEADBEEF, `oRspErr`=0, `read_en` high exactly 1 cycle.
- Write 0x12345678 to addr 3 against a registered-ack slave, then read addr 3 -> write response 3 cycles after accept; the read returns 0x12345678; the stale `write_ack` during RESP causes no effect.
- Hold `iRspReady`=0 for 10 cycles after a read -> `oRspValid`/`oRspData` held stable, `oCmdReady`=0 and a pending command is not taken until the handshake completes.
- With `BBUS_TIMEOUT_EN`, `timeout_cycles`=8, and a slave that never acks -> enable high for 8 cycles, then `oRspErr`=1, `oRspData`=0. With the ack arriving in the expiry cycle -> `oRspErr`=0.
- Assert `iRst` in the second cycle of a write -> `write_en`=0 and `oRspValid`=0 at the next edge, then `oCmdReady`=1 after reset is released.
- Back-to-back commands with `iRspReady` held high -> never both enables high, and at least 1 cycle with both enables low between transactions.
